// File: rtl/aes32_cmac_msg_fmt.sv
// CMAC message formatter: packs 32-bit message words into 128-bit blocks, pads and
// subkey-XORs the final block, and streams each block out as four words, MSW first.
module aes32_cmac_msg_fmt #(
   parameter int CNTW = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [127:0]    K1,
   input  logic [127:0]    K2,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     IN_DATA,
   input  logic            IN_LAST,
   input  logic [2:0]      IN_NBYTES,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [31:0]     OUT_DATA,
   output logic            OUT_SOB,
   output logic            OUT_LAST,
   output logic [CNTW-1:0] BLK_CNT,
   output logic            DONE
);

   typedef enum logic [1:0] {IDLE, FILL, PEND, EMIT} state_t;

   state_t          state_q, state_d;
   logic [127:0]    k1_q, k1_d, k2_q, k2_d, blk_q, blk_d;
   logic [1:0]      idx_q, idx_d, widx_q, widx_d;
   logic            fin_q, fin_d;
   logic [31:0]     la_data_q, la_data_d;
   logic            la_last_q, la_last_d;
   logic [2:0]      la_nb_q, la_nb_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_data_q, out_data_d;
   logic            out_sob_q, out_sob_d;
   logic            out_last_q, out_last_d;

   logic            in_fire, out_fire;
   logic [2:0]      nb_eff;
   logic [4:0]      tot;
   logic [127:0]    wr_blk, la_blk;

   // Keep the first tot bytes, place 0x80 right after them, zero the rest.
   function automatic logic [127:0] pad_blk(input logic [127:0] b, input logic [4:0] n);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < n)
            r[127-8*i -: 8] = b[127-8*i -: 8];
         else if (5'(i) == n)
            r[127-8*i -: 8] = 8'h80;
      end
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      k1_d      = k1_q;
      k2_d      = k2_q;
      blk_d     = blk_q;
      idx_d     = idx_q;
      widx_d    = widx_q;
      fin_d     = fin_q;
      la_data_d = la_data_q;
      la_last_d = la_last_q;
      la_nb_d   = la_nb_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;

      in_fire  = IN_VALID && in_ready_q;
      out_fire = out_valid_q && OUT_READY;

      // Non-final words always carry four bytes; out-of-range counts saturate at four.
      if (!IN_LAST || IN_NBYTES > 3'd4)
         nb_eff = 3'd4;
      else
         nb_eff = IN_NBYTES;
      tot = {1'b0, idx_q, 2'b00} + {2'b00, nb_eff};

      wr_blk = blk_q;
      wr_blk[127-32*int'(idx_q) -: 32] = IN_DATA;
      la_blk = {la_data_q, 96'b0};

      case (state_q)
         IDLE: begin
            if (START) begin
               k1_d      = K1;
               k2_d      = K2;
               blk_d     = '0;
               idx_d     = 2'd0;
               widx_d    = 2'd0;
               fin_d     = 1'b0;
               la_data_d = '0;
               la_last_d = 1'b0;
               la_nb_d   = 3'd0;
               cnt_d     = '0;
               state_d   = FILL;
            end
         end
         FILL: begin
            if (in_fire) begin
               if (IN_LAST) begin
                  if (nb_eff == 3'd4 && idx_q == 2'd3)
                     blk_d = wr_blk ^ k1_q;
                  else
                     blk_d = pad_blk(wr_blk, tot) ^ k2_q;
                  fin_d   = 1'b1;
                  widx_d  = 2'd0;
                  state_d = EMIT;
               end else begin
                  blk_d = wr_blk;
                  if (idx_q == 2'd3)
                     state_d = PEND;
                  else
                     idx_d = idx_q + 2'd1;
               end
            end
         end
         PEND: begin
            // One word of lookahead decides whether the full buffered block is the last.
            if (in_fire) begin
               la_data_d = IN_DATA;
               la_last_d = IN_LAST;
               la_nb_d   = nb_eff;
               widx_d    = 2'd0;
               state_d   = EMIT;
               if (IN_LAST && nb_eff == 3'd0) begin
                  blk_d = blk_q ^ k1_q;
                  fin_d = 1'b1;
               end else begin
                  fin_d = 1'b0;
               end
            end
         end
         EMIT: begin
            if (out_fire) begin
               widx_d = widx_q + 2'd1;
               if (widx_q == 2'd3) begin
                  cnt_d  = cnt_q + CNTW'(1);
                  widx_d = 2'd0;
                  if (fin_q) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else if (la_last_q) begin
                     blk_d     = pad_blk(la_blk, {2'b00, la_nb_q}) ^ k2_q;
                     fin_d     = 1'b1;
                     la_last_d = 1'b0;
                  end else begin
                     blk_d   = la_blk;
                     idx_d   = 2'd1;
                     state_d = FILL;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from next-state values so they leave the flops cleanly.
      in_ready_d  = (state_d == FILL) || (state_d == PEND);
      out_valid_d = (state_d == EMIT);
      out_data_d  = out_valid_d ? blk_d[127-32*int'(widx_d) -: 32] : 32'h0;
      out_sob_d   = out_valid_d && (widx_d == 2'd0);
      out_last_d  = out_valid_d && fin_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         k1_q        <= '0;
         k2_q        <= '0;
         blk_q       <= '0;
         idx_q       <= 2'd0;
         widx_q      <= 2'd0;
         fin_q       <= 1'b0;
         la_data_q   <= '0;
         la_last_q   <= 1'b0;
         la_nb_q     <= 3'd0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sob_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k1_q        <= k1_d;
         k2_q        <= k2_d;
         blk_q       <= blk_d;
         idx_q       <= idx_d;
         widx_q      <= widx_d;
         fin_q       <= fin_d;
         la_data_q   <= la_data_d;
         la_last_q   <= la_last_d;
         la_nb_q     <= la_nb_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sob_q   <= out_sob_d;
         out_last_q  <= out_last_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_SOB   = out_sob_q;
   assign OUT_LAST  = out_last_q;
   assign BLK_CNT   = cnt_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_aes32_cmac_msg_fmt.sv
// Testbench for aes32_cmac_msg_fmt: directed CMAC vectors plus random messages with
// random handshake gaps, checked against a byte-level padding/XOR reference model.
module tb_aes32_cmac_msg_fmt;

   localparam int CNTW = 16;

   logic            CLK = 1'b0;
   logic            RST;
   logic            START;
   logic [127:0]    K1, K2;
   logic            IN_VALID;
   logic            IN_READY;
   logic [31:0]     IN_DATA;
   logic            IN_LAST;
   logic [2:0]      IN_NBYTES;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic [31:0]     OUT_DATA;
   logic            OUT_SOB;
   logic            OUT_LAST;
   logic [CNTW-1:0] BLK_CNT;
   logic            DONE;

   int checks   = 0;
   int failures = 0;

   typedef struct { logic [31:0] data; logic sob; logic last; } outw_t;
   typedef struct { logic [31:0] data; logic last; logic [2:0] nb; } inw_t;

   logic [7:0]  msg[$];
   logic [31:0] wordBuf[$];
   outw_t       expQ[$];
   inw_t        inQ[$];
   logic [31:0] gotQ[$];

   localparam logic [127:0] TK1 = 128'hfbeed618_35713366_7c85e08f_7236a8de;
   localparam logic [127:0] TK2 = 128'hf7ddac30_6ae266cc_f90bc11e_e46d513b;

   aes32_cmac_msg_fmt #(.CNTW(CNTW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .K1(K1), .K2(K2),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .IN_LAST(IN_LAST), .IN_NBYTES(IN_NBYTES),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .OUT_SOB(OUT_SOB), .OUT_LAST(OUT_LAST), .BLK_CNT(BLK_CNT), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic checkGot(input string tag, input int i, input logic [31:0] exp);
      if (i < gotQ.size())
         checkOutput(tag, 128'(gotQ[i]), 128'(exp));
      else
         checkOutput({tag, "_count"}, 128'(gotQ.size()), 128'(i + 1));
   endtask

   // Reference model: CMAC blocking from the byte string alone.
   function automatic void buildModel(input logic [127:0] k1, input logic [127:0] k2);
      int L, nb;
      logic [127:0] blk;
      outw_t w;
      expQ.delete();
      L  = msg.size();
      nb = (L == 0) ? 1 : (L + 15) / 16;
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int i = 0; i < 16; i++) begin
            int p = b * 16 + i;
            if (p < L)       blk[127-8*i -: 8] = msg[p];
            else if (p == L) blk[127-8*i -: 8] = 8'h80;
         end
         if (b == nb - 1)
            blk = blk ^ ((L > 0 && L % 16 == 0) ? k1 : k2);
         for (int j = 0; j < 4; j++) begin
            w.data = blk[127-32*j -: 32];
            w.sob  = (j == 0);
            w.last = (b == nb - 1);
            expQ.push_back(w);
         end
      end
   endfunction

   // Word stream for the byte string; garbage fills unused bytes of the final word.
   function automatic void buildInput(input bit emptyTail);
      int L, nw;
      bit tail;
      inw_t w;
      inQ.delete();
      L = msg.size();
      tail = emptyTail || (L == 0);
      nw = (L + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         w.data = $urandom;
         for (int j = 0; j < 4; j++)
            if (4 * k + j < L) w.data[31-8*j -: 8] = msg[4*k+j];
         w.last = (k == nw - 1) && !(tail && L % 4 == 0);
         if (w.last)
            w.nb = (L - 4 * k >= 4) ? 3'd4 : 3'(L - 4 * k);
         else
            w.nb = 3'($urandom_range(7));
         inQ.push_back(w);
      end
      if (tail && L % 4 == 0) begin
         w.data = $urandom;
         w.last = 1'b1;
         w.nb   = 3'd0;
         inQ.push_back(w);
      end
   endfunction

   function automatic void msgFromWords(input int L);
      msg.delete();
      for (int i = 0; i < L; i++) msg.push_back(wordBuf[i/4][31-8*(i%4) -: 8]);
   endfunction

   task automatic driveWord(input int wi, input int validPct);
      if (wi < inQ.size()) begin
         IN_VALID  = ($urandom_range(99) < validPct);
         IN_DATA   = inQ[wi].data;
         IN_LAST   = inQ[wi].last;
         IN_NBYTES = inQ[wi].nb;
      end else begin
         IN_VALID  = 1'b0;
         IN_DATA   = $urandom;
         IN_LAST   = 1'($urandom_range(1));
         IN_NBYTES = 3'($urandom_range(7));
      end
   endtask

   // Runs one message; abortAt>0 applies RST once that many words have left the DUT.
   task automatic applyStimulus(input logic [127:0] k1, input logic [127:0] k2, input int readyPct,
                                input int validPct, input int abortAt, input bit emptyTail);
      int wi = 0, ei = 0, cycles = 0;
      bit doneSeen = 0, stalled = 0, inFire, aborted = 0;
      logic [31:0] heldData;
      logic heldSob, heldLast;
      gotQ.delete();
      buildModel(k1, k2);
      buildInput(emptyTail);
      @(posedge CLK); #1;
      K1 = k1; K2 = k2; START = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
      @(posedge CLK); #1;
      START = 1'b0;
      K1 = {$urandom, $urandom, $urandom, $urandom};
      K2 = {$urandom, $urandom, $urandom, $urandom};
      driveWord(wi, validPct);
      OUT_READY = ($urandom_range(99) < readyPct);
      while (!doneSeen && cycles < 3000) begin
         @(negedge CLK);
         cycles++;
         if (abortAt > 0 && ei >= abortAt && OUT_VALID) begin
            aborted = 1;
            break;
         end
         if (stalled) begin
            checkOutput("hold_valid", 128'(OUT_VALID), 128'(1));
            checkOutput("hold_data", 128'(OUT_DATA), 128'(heldData));
            checkOutput("hold_sob", 128'(OUT_SOB), 128'(heldSob));
            checkOutput("hold_last", 128'(OUT_LAST), 128'(heldLast));
         end
         stalled  = OUT_VALID && !OUT_READY;
         heldData = OUT_DATA;
         heldSob  = OUT_SOB;
         heldLast = OUT_LAST;
         if (OUT_VALID && OUT_READY) begin
            gotQ.push_back(OUT_DATA);
            if (ei < expQ.size()) begin
               checkOutput("out_data", 128'(OUT_DATA), 128'(expQ[ei].data));
               checkOutput("out_sob", 128'(OUT_SOB), 128'(expQ[ei].sob));
               checkOutput("out_last", 128'(OUT_LAST), 128'(expQ[ei].last));
               if (expQ[ei].sob)
                  checkOutput("blk_cnt_sob", 128'(BLK_CNT), 128'(ei / 4));
            end else begin
               checkOutput("extra_word", 128'(ei), 128'(expQ.size()));
            end
            ei++;
         end
         if (DONE) begin
            doneSeen = 1;
            checkOutput("done_words", 128'(ei), 128'(expQ.size()));
            checkOutput("blk_cnt", 128'(BLK_CNT), 128'(expQ.size() / 4));
         end
         inFire = IN_VALID && IN_READY;
         @(posedge CLK); #1;
         if (inFire) wi++;
         driveWord(wi, validPct);
         OUT_READY = ($urandom_range(99) < readyPct);
      end
      IN_VALID = 1'b0;
      if (abortAt > 0) begin
         checkOutput("abort_reached", 128'(aborted), 128'(1));
         RST = 1'b1;
         @(posedge CLK); #1;
         RST = 1'b0;
         @(negedge CLK);
         checkOutput("abort_outs", {OUT_DATA, BLK_CNT, IN_READY, OUT_VALID, OUT_SOB, OUT_LAST, DONE},
                     '0);
         for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checkOutput("abort_no_done", 128'(DONE), 128'(0));
         end
      end else if (!doneSeen) begin
         checkOutput("done_timeout", 128'(doneSeen), 128'(1));
      end else begin
         @(negedge CLK);
         checkOutput("done_pulse", 128'(DONE), 128'(0));
         checkOutput("idle_valid", 128'(OUT_VALID), 128'(0));
      end
   endtask

   task automatic loadNist(input int nWords);
      logic [31:0] nist [16] = '{
         32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a,
         32'hae2d8a57, 32'h1e03ac9c, 32'h9eb76fac, 32'h45af8e51,
         32'h30c81c46, 32'ha35ce411, 32'he5fbc119, 32'h1a0a52ef,
         32'hf69f2445, 32'hdf4f9b17, 32'had2b417b, 32'he66c3710};
      wordBuf.delete();
      for (int i = 0; i < nWords; i++) wordBuf.push_back(nist[i]);
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; K1 = '0; K2 = '0;
      IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; IN_NBYTES = '0; OUT_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checkOutput("reset_outs", {OUT_DATA, BLK_CNT, IN_READY, OUT_VALID, OUT_SOB, OUT_LAST, DONE}, '0);

      msg.delete();
      applyStimulus(TK1, TK2, 100, 100, 0, 0);
      checkGot("empty_w0", 0, 32'h77ddac30);
      checkGot("empty_w3", 3, 32'he46d513b);

      loadNist(4); msgFromWords(16);
      applyStimulus(TK1, TK2, 100, 100, 0, 0);
      checkGot("m16_w0", 0, 32'h902f68fa);
      checkGot("m16_w3", 3, 32'h01a5bff4);

      loadNist(10); msgFromWords(40);
      applyStimulus(TK1, TK2, 80, 90, 0, 0);
      checkGot("m40_raw", 4, 32'hae2d8a57);
      checkGot("m40_w8", 8, 32'hc715b076);
      checkGot("m40_w10", 10, 32'h790bc11e);

      loadNist(1); msgFromWords(1);
      applyStimulus(TK1, TK2, 100, 100, 0, 0);
      checkGot("m1_w0", 0, 32'h9c5dac30);

      loadNist(16); msgFromWords(64);
      applyStimulus(TK1, TK2, 50, 100, 0, 0);
      checkGot("m64_w12", 12, 32'h0d71f25d);
      checkGot("m64_w15", 15, 32'h945a9fce);

      // Same 64 bytes but the length is signalled by a trailing empty LAST word.
      applyStimulus(TK1, TK2, 60, 70, 0, 1);
      checkGot("m64t_w12", 12, 32'h0d71f25d);

      applyStimulus(TK1, TK2, 70, 100, 5, 0);
      msg.delete();
      applyStimulus(TK1, TK2, 100, 100, 0, 0);
      checkGot("post_reset_w0", 0, 32'h77ddac30);

      for (int t = 0; t < 30; t++) begin
         int L = $urandom_range(70);
         msg.delete();
         for (int i = 0; i < L; i++) msg.push_back(8'($urandom));
         applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                       $urandom_range(100, 30), $urandom_range(100, 50), 0, 1'($urandom_range(1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes32_cmac_msg_fmt.md
Name: aes32_cmac_msg_fmt

Overview:
Upstream message formatter for the aes32_dsp_cmac core. It accepts a CMAC message as a stream of 32-bit words with a byte count on the final word and assembles it into 128-bit blocks. It detects the final block, applies 0x80/zero padding to a partial final block, and XORs the final block with K1 (complete block) or K2 (partial or empty block). Blocks are emitted as four serial 32-bit words, most-significant word first, in the order the CMAC core consumes DIN.

Parameters:
CNTW, 16, width of the emitted-block counter BLK_CNT (wraps modulo 2^CNTW)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
START  in  1  begin a new message; sampled only in IDLE
K1  in  128  CMAC subkey K1; captured on START
K2  in  128  CMAC subkey K2; captured on START
IN_VALID  in  1  input word valid
IN_READY  out  1  formatter can accept a word
IN_DATA  in  32  message word; byte0 = bits 31:24
IN_LAST  in  1  word is the final word of the message
IN_NBYTES  in  3  valid bytes in the final word (0..4); ignored when IN_LAST=0 (treated as 4)
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  downstream accepts OUT_DATA
OUT_DATA  out  32  block word, bits 127:96 first
OUT_SOB  out  1  first word of a block
OUT_LAST  out  1  word belongs to the final, subkey-XORed block
BLK_CNT  out  CNTW  blocks fully emitted in the current message
DONE  out  1  one-cycle pulse after the final block's 4th word is accepted

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE; IN_READY, OUT_VALID, OUT_SOB, OUT_LAST, DONE, OUT_DATA, BLK_CNT = 0; all buffers and flags cleared. Reset mid-message aborts immediately with no DONE.
- Input handshake: a word transfers when IN_VALID & IN_READY at a rising edge. Output handshake: a word transfers when OUT_VALID & OUT_READY. OUT_DATA, OUT_SOB and OUT_LAST are held stable while OUT_VALID & !OUT_READY.
- States: IDLE, FILL, PEND, EMIT.
- IDLE: IN_READY=0. On START: capture K1/K2, clear the block buffer, set word index idx=0, clear BLK_CNT, go to FILL. START outside IDLE is ignored.
- FILL: IN_READY=1. The accepted word is written to buf[idx].
  - IN_LAST with IN_NBYTES=4 and idx=3: the block is complete and final; XOR with K1 and go to EMIT.
  - Any other IN_LAST case: the block holds 4*idx+IN_NBYTES bytes, always fewer than 16. Put 0x80 in the first unused byte and zero all later bytes, XOR with K2, go to EMIT. This includes the empty message: idx=0, NBYTES=0 gives 0x80 followed by zeros.
  - Not last and idx=3: go to PEND. Otherwise idx++.
- PEND: the buffer is full but its finality is unknown. IN_READY=1; one lookahead word is accepted into the LA register along with its LAST/NBYTES.
  - LA is LAST with NBYTES=0: the buffered block is final; XOR with K1; EMIT with final=1.
  - Otherwise: EMIT with final=0; LA is retained.
- EMIT: IN_READY=0. OUT_VALID is high from the first cycle in EMIT, one cycle after the accepting input edge. Four words are emitted; OUT_SOB is set on word 0 and OUT_LAST on all four words when final=1. On the 4th accepted word, BLK_CNT increments.
  - final=1: DONE pulses for the next cycle; go to IDLE.
  - final=0: clear the buffer and move LA into buf[0]. If LA was LAST (NBYTES 1..4), pad and XOR with K2 (4*0+NBYTES bytes, partial) and stay in EMIT with final=1. Otherwise go to FILL with idx=1.
- The subkey XOR is applied only to the final block. Non-final blocks pass through unmodified.

Test Plan:
- Empty message: START with K1=fbeed618_35713366_7c85e08f_7236a8de, K2=f7ddac30_6ae266cc_f90bc11e_e46d513b, then one word LAST, NBYTES=0 -> OUT words 77ddac30, 6ae266cc, f90bc11e, e46d513b; OUT_LAST=1; BLK_CNT=1; DONE pulse.
- 16-byte message 6BC1BEE2_2E409F96_E93D7E11_7393172A, last word NBYTES=4 -> 902F68FA, 1B31ACF0, 95B89E9E, 01A5BFF4 (XORed with K1); OUT_LAST=1.
- 40-byte message (PT0, PT1, then 30C81C46, A35CE411 with the last word NBYTES=4) -> PT0 raw, PT1 raw with OUT_LAST=0, then C715B076, C9BE82DD, 790BC11E, E46D513B with OUT_LAST=1; BLK_CNT=3.
- 1-byte message 6Bxxxxxx, LAST, NBYTES=1 -> 9C5DAC30, 6ae266cc, f90bc11e, e46d513b.
- 64-byte NIST message with OUT_READY toggled pseudo-randomly -> blocks 1-3 raw, block 4 = f69f2445…3710 XOR K1 = 0d71f25d_ea3ea871_d1aea1f4_945a9fce; OUT_DATA stable during stalls; no word lost or duplicated.
- RST asserted during EMIT of block 2 -> next cycle all outputs 0 and no DONE; a following START/empty message produces the correct result.
